fnd_apb_ctrl_n: RTL and testbench
=================================

Name: fnd_apb_ctrl_n

Overview:
Parametrised APB3 seven-segment (FND) display peripheral; successor to the fixed 4-digit decimal FND block.
- Drives NUM_DIGITS multiplexed common-anode digits.
- Decimal mode uses a multi-cycle sequential binary-to-BCD converter; hex mode displays nibbles directly.
- Adds per-digit decimal points, blink, leading-zero blanking, display enable and a readable status register.
- Sits on the APB bus of the multi-cycle RISC-V system alongside the other peripherals.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (1..8)
SCAN_DIV, 100_000, PCLK cycles per digit-scan tick (must be >= 2)
BLINK_DIV, 500, scan ticks per blink half-period (must be >= 1)

Ports:
PCLK  in  1  APB clock
PRESET  in  1  reset
PADDR  in  4  byte address; bits [3:2] select the register
PWRITE  in  1  write strobe
PENABLE  in  1  access phase
PWDATA  in  32  write data
PSEL  in  1  peripheral select
PRDATA  out  32  read data
PREADY  out  1  transfer complete
fnd_data  out  8  active-low segments {dp,g,f,e,d,c,b,a}
fnd_com  out  NUM_DIGITS  active-low digit select, one-hot

Behaviour:
- Reset: PRESET, asynchronous, active-high; clock PCLK. All registers 0, PREADY=0, PRDATA=0, fnd_data=8'hFF, fnd_com=all ones, scan index 0, blink phase on, converter idle, digit latches 0.
- Registers (PADDR[3:2]):
  - 0 CTRL [3:0]: [0] enable, [1] mode (0 = decimal, 1 = hex), [2] blink_en, [3] lz_blank.
  - 1 VALUE [4*NUM_DIGITS-1:0].
  - 2 DP [NUM_DIGITS-1:0].
  - 3 STATUS, read-only: [0] conv_busy, [7:4] NUM_DIGITS.
- Unimplemented bits read 0. Writes to STATUS are ignored.
- APB handshake:
  - An access is accepted when PSEL && PENABLE && !PREADY.
  - PREADY is high for exactly the next cycle, then low.
  - Write data is captured on the accept edge.
  - PRDATA is registered on the accept edge and held until the next read.
  - Every access takes 1 wait state.
- Conversion:
  - Triggered by a write to VALUE, or by a CTRL write while mode = 0.
  - In hex mode, a VALUE write loads the digit latches directly with VALUE nibbles on the accept edge.
  - In decimal mode, double-dabble runs 1 shift per cycle for 4*NUM_DIGITS cycles. conv_busy=1 from the cycle after the trigger until the cycle the latches update.
  - Result is VALUE mod 10^NUM_DIGITS, i.e. the low BCD digits.
  - A new trigger while busy aborts and restarts with the new value.
  - Digit latches keep their old content until completion, so the display never shows partial results.
- Scan:
  - Prescaler counts 0..SCAN_DIV-1. At terminal count, scan index increments and wraps from NUM_DIGITS-1 to 0.
  - fnd_com and fnd_data are registered, updating 1 cycle after the index changes.
  - Digit k enables fnd_com[k]=0 and shows latch k, seg LUT 0-F. fnd_data[7] = ~DP[k].
- Blanking:
  - With lz_blank=1 and mode = 0, digits above the most significant nonzero digit show 7'h7F. DP is still applied.
  - Digit 0 is never blanked.
- Blink:
  - When blink_en=1, the phase toggles every BLINK_DIV scan ticks. In the off phase, fnd_com is all ones.
  - When blink_en=0, phase is forced on and the blink counter is held at 0.
- Display disable: when enable=0, fnd_com is all ones and fnd_data is 8'hFF. Scan and conversion keep running.

Decomposition:
- fnd_pkg:
  - Register offsets (CTRL/VALUE/DP/STATUS).
  - CTRL bit-index constants.
  - Mode enum (MODE_DEC, MODE_HEX).
  - seg7 function (4-bit to 7-bit active-low, 0-F).
  - Converter state enum (IDLE, SHIFT, DONE).
- Sub-module bin2bcd_seq, parametrised by NUM_DIGITS: start/abort, bin in, busy, done pulse, bcd out.

Test Plan:
- NUM_DIGITS=4, SCAN_DIV=4, decimal mode, enable=1. Write VALUE=1234 -> STATUS.busy=1 for 16 cycles, then the scan shows com 1110/1101/1011/0111 with data 8'h99/B0/A4/F9.
- Hex mode, write VALUE=16'hBEEF -> latches update immediately. Digit 0 shows 8'h8E, digit 3 shows 8'h83, no busy.
- Decimal mode, lz_blank=1, VALUE=7, DP=4'b0100 -> digit 0 = 8'hF8, digit 1 = 8'hFF, digit 2 = 8'h7F, digit 3 = 8'hFF. VALUE=12345 -> shows 2345.
- Write VALUE=9999, then write VALUE=1 3 cycles later -> single completion. Display goes straight from the old digits to 0001, never 9999.
- blink_en=1, BLINK_DIV=2 -> fnd_com all ones for 2 scan ticks, active for 2, repeating. Clearing enable -> fnd_com=4'hF, fnd_data=8'hFF.
- Read every register after writes; check PREADY is a one-cycle pulse per access and PRDATA is correct. Assert PRESET mid-conversion and mid-scan -> all outputs at reset values immediately.

Source files
------------

// File: rtl/fnd_apb_ctrl_n_pkg.sv
// fnd_apb_ctrl_n_pkg: register map, CTRL bit positions, mode/converter enums and 7-segment LUT
package fnd_apb_ctrl_n_pkg;
  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_VALUE  = 2'd1;
  localparam logic [1:0] REG_DP     = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;
  localparam int CTRL_EN    = 0;
  localparam int CTRL_MODE  = 1;
  localparam int CTRL_BLINK = 2;
  localparam int CTRL_LZ    = 3;
  typedef enum logic {MODE_DEC = 1'b0, MODE_HEX = 1'b1} mode_e;
  typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} conv_state_e;
  // active-low {g,f,e,d,c,b,a}
  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;
      4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;
      4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;
      4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;
      4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;
      4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;
      4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;
      4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction
endpackage

// File: rtl/fnd_apb_ctrl_n_if.sv
// fnd_apb_ctrl_n_if: APB3 bus signals seen by the FND peripheral
interface fnd_apb_ctrl_n_if;
  logic [3:0]  PADDR;
  logic        PWRITE;
  logic        PENABLE;
  logic        PSEL;
  logic [31:0] PWDATA;
  logic [31:0] PRDATA;
  logic        PREADY;
  modport master(output PADDR, PWRITE, PENABLE, PSEL, PWDATA, input PRDATA, PREADY);
  modport slave(input PADDR, PWRITE, PENABLE, PSEL, PWDATA, output PRDATA, PREADY);
endinterface

// File: rtl/fnd_apb_ctrl_n_bin2bcd_seq.sv
// fnd_apb_ctrl_n_bin2bcd_seq: one-shift-per-cycle double-dabble, keeps only the low NUM_DIGITS BCD digits
module fnd_apb_ctrl_n_bin2bcd_seq
  import fnd_apb_ctrl_n_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    PCLK,
  input  logic                    PRESET,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [4*NUM_DIGITS-1:0] i_bin,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [4*NUM_DIGITS-1:0] o_bcd
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int CW = $clog2(W);
  conv_state_e    r_state;
  logic [CW-1:0]  r_cnt;
  logic [W-1:0]   r_sr;
  logic [W-1:0]   r_bcd;
  logic [W-1:0]   w_adj;
  // carries out of the top digit are dropped, which yields the value mod 10^NUM_DIGITS
  always_comb begin
    w_adj = r_bcd;
    for (int d = 0; d < NUM_DIGITS; d++)
      if (r_bcd[4*d +: 4] >= 4'd5) w_adj[4*d +: 4] = r_bcd[4*d +: 4] + 4'd3;
  end
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sr    <= '0;
      r_bcd   <= '0;
    end else if (i_start) begin
      r_state <= SHIFT;
      r_cnt   <= '0;
      r_sr    <= i_bin;
      r_bcd   <= '0;
    end else if (i_abort) begin
      r_state <= IDLE;
    end else if (r_state == SHIFT) begin
      r_bcd   <= {w_adj[W-2:0], r_sr[W-1]};
      r_sr    <= r_sr << 1;
      r_cnt   <= r_cnt + 1'b1;
      r_state <= r_cnt == CW'(W - 1) ? DONE : SHIFT;
    end else if (r_state == DONE) begin
      r_state <= IDLE;
    end
  end
  assign o_busy = r_state == SHIFT;
  assign o_done = r_state == DONE;
  assign o_bcd  = r_bcd;
endmodule

// File: rtl/fnd_apb_ctrl_n.sv
// fnd_apb_ctrl_n: APB3 multiplexed seven-segment display controller with decimal/hex modes, DP, blink and blanking
module fnd_apb_ctrl_n
  import fnd_apb_ctrl_n_pkg::*;
#(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100_000,
  parameter int BLINK_DIV  = 500
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  fnd_apb_ctrl_n_if.slave       apb,
  output logic [7:0]            fnd_data,
  output logic [NUM_DIGITS-1:0] fnd_com
);
  localparam int W  = 4 * NUM_DIGITS;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int SW = $clog2(SCAN_DIV);
  localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
  logic                  r_pready;
  logic [31:0]           r_prdata;
  logic [3:0]            r_ctrl;
  logic [W-1:0]          r_value;
  logic [NUM_DIGITS-1:0] r_dp;
  logic [W-1:0]          r_dig;
  logic [SW-1:0]         r_pre;
  logic [IW-1:0]         r_idx;
  logic [BW-1:0]         r_bcnt;
  logic                  r_phase;
  logic [7:0]            r_data;
  logic [NUM_DIGITS-1:0] r_com;
  logic [1:0]            w_addr;
  logic                  w_acc, w_wr_ctrl, w_wr_val, w_wr_dp;
  logic                  w_start, w_abort, w_busy, w_done;
  logic [W-1:0]          w_bcd;
  logic [31:0]           w_rdata;
  logic                  w_tick, w_blink_end;
  logic [3:0]            w_dig;
  logic                  w_dp, w_blk, w_run;
  logic [6:0]            w_seg;
  mode_e                 w_mode, w_new_mode;
  logic                  w_unused;
  assign w_addr      = apb.PADDR[3:2];
  assign w_acc       = apb.PSEL && apb.PENABLE && !r_pready;
  assign w_wr_ctrl   = w_acc && apb.PWRITE && w_addr == REG_CTRL;
  assign w_wr_val    = w_acc && apb.PWRITE && w_addr == REG_VALUE;
  assign w_wr_dp     = w_acc && apb.PWRITE && w_addr == REG_DP;
  assign w_mode      = mode_e'(r_ctrl[CTRL_MODE]);
  assign w_new_mode  = mode_e'(apb.PWDATA[CTRL_MODE]);
  // a hex-mode VALUE write or a switch into hex cancels any conversion still in flight
  assign w_start     = (w_wr_val && w_mode == MODE_DEC) || (w_wr_ctrl && w_new_mode == MODE_DEC);
  assign w_abort     = (w_wr_val && w_mode == MODE_HEX) || (w_wr_ctrl && w_new_mode == MODE_HEX);
  assign w_rdata     = w_addr == REG_CTRL  ? {28'd0, r_ctrl} :
                       w_addr == REG_VALUE ? 32'(r_value) :
                       w_addr == REG_DP    ? 32'(r_dp) :
                       {24'd0, 4'(NUM_DIGITS), 3'd0, w_busy};
  assign w_unused    = &{1'b0, apb.PADDR[1:0], apb.PWDATA};
  fnd_apb_ctrl_n_bin2bcd_seq #(.NUM_DIGITS(NUM_DIGITS)) u_conv (
    .PCLK    (PCLK),
    .PRESET  (PRESET),
    .i_start (w_start),
    .i_abort (w_abort),
    .i_bin   (w_wr_val ? apb.PWDATA[W-1:0] : r_value),
    .o_busy  (w_busy),
    .o_done  (w_done),
    .o_bcd   (w_bcd)
  );
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_pready <= 1'b0;
      r_prdata <= '0;
      r_ctrl   <= '0;
      r_value  <= '0;
      r_dp     <= '0;
      r_dig    <= '0;
    end else begin
      r_pready <= w_acc;
      if (w_acc && !apb.PWRITE) r_prdata <= w_rdata;
      if (w_wr_ctrl) r_ctrl <= apb.PWDATA[3:0];
      if (w_wr_val) r_value <= apb.PWDATA[W-1:0];
      if (w_wr_dp) r_dp <= apb.PWDATA[NUM_DIGITS-1:0];
      if (w_wr_val && w_mode == MODE_HEX) r_dig <= apb.PWDATA[W-1:0];
      else if (w_done) r_dig <= w_bcd;
    end
  end
  assign w_tick      = r_pre == SW'(SCAN_DIV - 1);
  assign w_blink_end = r_bcnt == BW'(BLINK_DIV - 1);
  // w_run stays set while every digit from the top down to k is zero; digit 0 never qualifies
  always_comb begin
    w_dig = '0;
    w_dp  = 1'b0;
    w_blk = 1'b0;
    w_run = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      w_run = w_run && k != 0 && r_dig[4*k +: 4] == 4'd0;
      if (r_idx == IW'(k)) begin
        w_dig = r_dig[4*k +: 4];
        w_dp  = r_dp[k];
        w_blk = w_run;
      end
    end
  end
  assign w_seg = (w_blk && r_ctrl[CTRL_LZ] && w_mode == MODE_DEC) ? 7'h7F : seg7(w_dig);
  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_pre   <= '0;
      r_idx   <= '0;
      r_bcnt  <= '0;
      r_phase <= 1'b1;
      r_data  <= 8'hFF;
      r_com   <= '1;
    end else begin
      r_pre <= w_tick ? '0 : r_pre + 1'b1;
      if (w_tick) r_idx <= r_idx == IW'(NUM_DIGITS - 1) ? '0 : r_idx + 1'b1;
      if (!r_ctrl[CTRL_BLINK]) begin
        r_bcnt  <= '0;
        r_phase <= 1'b1;
      end else if (w_tick) begin
        r_bcnt  <= w_blink_end ? '0 : r_bcnt + 1'b1;
        r_phase <= w_blink_end ? !r_phase : r_phase;
      end
      r_data <= r_ctrl[CTRL_EN] ? {~w_dp, w_seg} : 8'hFF;
      r_com  <= (r_ctrl[CTRL_EN] && r_phase) ? ~(NUM_DIGITS'(1) << r_idx) : '1;
    end
  end
  assign apb.PREADY = r_pready;
  assign apb.PRDATA = r_prdata;
  assign fnd_data   = r_data;
  assign fnd_com    = r_com;
endmodule

// File: tb/tb_fnd_apb_ctrl_n.sv
// tb_fnd_apb_ctrl_n: table-driven display vectors, scoreboarded register reads and multi-cycle corner sequences
module tb_fnd_apb_ctrl_n;
  logic       PCLK = 1'b0;
  logic       PRESET = 1'b1;
  logic [7:0] fnd_data;
  logic [3:0] fnd_com;
  int         n_vec = 0;
  int         n_bad = 0;
  logic [31:0] q_exp[$];
  typedef struct packed {
    logic [3:0]  ctrl;
    logic [3:0]  dp;
    logic [31:0] value;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [11];
  fnd_apb_ctrl_n_if apb();
  fnd_apb_ctrl_n #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLINK_DIV(2)) dut (
    .PCLK     (PCLK),
    .PRESET   (PRESET),
    .apb      (apb),
    .fnd_data (fnd_data),
    .fnd_com  (fnd_com)
  );
  always #5 PCLK = ~PCLK;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask
  task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata, output logic [31:0] rdata);
    int n = 0;
    @(posedge PCLK); #1;
    apb.PSEL = 1'b1; apb.PENABLE = 1'b0; apb.PWRITE = wr; apb.PADDR = addr; apb.PWDATA = wdata;
    @(posedge PCLK); #1;
    apb.PENABLE = 1'b1;
    do begin
      @(posedge PCLK); #1;
      n++;
    end while (!apb.PREADY && n < 8);
    chk("wait_states", 32'(n), 32'd1);
    rdata = apb.PRDATA;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0;
    @(posedge PCLK); #1;
    chk("pready_pulse", {31'd0, apb.PREADY}, 32'd0);
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    logic [31:0] x;
    apb_xfer(1'b1, a, d, x);
  endtask
  task automatic rd(input string nm, input logic [3:0] a, input logic [31:0] e);
    logic [31:0] x;
    q_exp.push_back(e);
    apb_xfer(1'b0, a, 32'd0, x);
    chk(nm, x, q_exp.pop_front());
  endtask
  task automatic check_scan(input string nm, input logic [31:0] e);
    for (int k = 0; k < 4; k++) begin
      int n = 0;
      logic [3:0] tgt;
      tgt = ~(4'b0001 << k);
      do begin
        @(negedge PCLK);
        n++;
      end while (fnd_com !== tgt && n < 64);
      chk($sformatf("%s_com%0d", nm, k), {28'd0, fnd_com}, {28'd0, tgt});
      chk($sformatf("%s_dig%0d", nm, k), {24'd0, fnd_data}, {24'd0, e[8*k +: 8]});
    end
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int b, d, s9, off, run, mx, bad;
    apb.PSEL = 1'b0; apb.PENABLE = 1'b0; apb.PWRITE = 1'b0; apb.PADDR = '0; apb.PWDATA = '0;
    vt[0]  = '{4'h1, 4'h0, 32'd1234,       32'hF9A4B099};
    vt[1]  = '{4'h3, 4'h0, 32'h0000BEEF,   32'h8386868E};
    vt[2]  = '{4'h9, 4'h4, 32'd7,          32'hFF7FFFF8};
    vt[3]  = '{4'h9, 4'h0, 32'd12345,      32'hA4B09992};
    vt[4]  = '{4'h1, 4'hF, 32'd0,          32'h40404040};
    vt[5]  = '{4'h9, 4'h0, 32'd0,          32'hFFFFFFC0};
    vt[6]  = '{4'hB, 4'h0, 32'h00000012,   32'hC0C0F9A4};
    vt[7]  = '{4'h1, 4'h0, 32'd10000,      32'hC0C0C0C0};
    vt[8]  = '{4'h9, 4'h0, 32'd9050,       32'h90C092C0};
    vt[9]  = '{4'h3, 4'h8, 32'h00001A2D,   32'h7988A4A1};
    vt[10] = '{4'h1, 4'hF, 32'hFFFFFFFF,   32'h12123012};
    repeat (3) @(posedge PCLK);
    #1;
    chk("rst_data", {24'd0, fnd_data}, 32'h000000FF);
    chk("rst_com", {28'd0, fnd_com}, 32'h0000000F);
    chk("rst_pready", {31'd0, apb.PREADY}, 32'd0);
    chk("rst_prdata", apb.PRDATA, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    rd("rst_ctrl", 4'h0, 32'd0);
    rd("rst_value", 4'h4, 32'd0);
    rd("rst_dp", 4'h8, 32'd0);
    rd("rst_status", 4'hC, 32'h40);
    chk("off_data", {24'd0, fnd_data}, 32'h000000FF);
    // decimal conversion length and busy flag
    wr(4'h0, 32'h1);
    repeat (20) @(posedge PCLK);
    b = 0;
    fork
      wr(4'h4, 32'd1234);
      repeat (40) begin
        @(negedge PCLK);
        if (dut.u_conv.o_busy) b++;
      end
    join
    chk("busy_cycles", 32'(b), 32'd16);
    wr(4'h4, 32'd1234);
    rd("status_busy", 4'hC, 32'h41);
    repeat (20) @(posedge PCLK);
    rd("status_idle", 4'hC, 32'h40);
    check_scan("dec1234", 32'hF9A4B099);
    // hex load is immediate, no conversion
    wr(4'h0, 32'h3);
    wr(4'h4, 32'h0000BEEF);
    rd("hex_nobusy", 4'hC, 32'h40);
    check_scan("hexbeef", 32'h8386868E);
    // restart: 9999 is aborted by 1 before it completes
    wr(4'h0, 32'h1);
    wr(4'h4, 32'd1234);
    repeat (24) @(posedge PCLK);
    d = 0; s9 = 0;
    fork
      begin
        wr(4'h4, 32'd9999);
        wr(4'h4, 32'd1);
      end
      repeat (60) begin
        @(negedge PCLK);
        if (dut.u_conv.o_done) d++;
        if (fnd_data[6:0] == 7'h10) s9++;
      end
    join
    chk("restart_done", 32'(d), 32'd1);
    chk("restart_no9", 32'(s9), 32'd0);
    check_scan("restart", 32'hC0C0C0F9);
    // table-driven display vectors
    for (int i = 0; i < 11; i++) begin
      wr(4'h0, {28'd0, vt[i].ctrl});
      wr(4'h8, {28'd0, vt[i].dp});
      wr(4'h4, vt[i].value);
      rd($sformatf("v%0d_value", i), 4'h4, vt[i].value & 32'h0000FFFF);
      repeat (20) @(posedge PCLK);
      check_scan($sformatf("v%0d", i), vt[i].exp);
    end
    // blink: phase flips every 2 scan ticks of 4 cycles -> 8 off, 8 on
    wr(4'h8, 32'h0);
    wr(4'h0, 32'h5);
    off = 0; run = 0; mx = 0;
    repeat (64) begin
      @(negedge PCLK);
      if (fnd_com == 4'hF) begin
        off++;
        run++;
        if (run > mx) mx = run;
      end else run = 0;
    end
    chk("blink_off", 32'(off), 32'd32);
    chk("blink_run", 32'(mx), 32'd8);
    // disable forces blank outputs
    wr(4'h0, 32'h0);
    bad = 0;
    repeat (20) begin
      @(negedge PCLK);
      if (fnd_com !== 4'hF || fnd_data !== 8'hFF) bad++;
    end
    chk("disable_bad", 32'(bad), 32'd0);
    // register readback, unimplemented bits, read-only STATUS
    wr(4'h0, 32'hFFFFFFF1);
    rd("ctrl_mask", 4'h0, 32'h1);
    wr(4'h8, 32'hFFFFFFFF);
    rd("dp_mask", 4'h8, 32'hF);
    wr(4'hC, 32'hFFFFFFFF);
    repeat (20) @(posedge PCLK);
    rd("status_ro", 4'hC, 32'h40);
    // reset in the middle of a conversion and scan
    wr(4'h4, 32'd4321);
    repeat (3) @(posedge PCLK);
    #3 PRESET = 1'b1;
    #1;
    chk("mid_rst_data", {24'd0, fnd_data}, 32'h000000FF);
    chk("mid_rst_com", {28'd0, fnd_com}, 32'h0000000F);
    chk("mid_rst_busy", {31'd0, dut.u_conv.o_busy}, 32'd0);
    chk("mid_rst_prdata", apb.PRDATA, 32'd0);
    chk("mid_rst_pready", {31'd0, apb.PREADY}, 32'd0);
    @(negedge PCLK);
    PRESET = 1'b0;
    rd("post_rst_ctrl", 4'h0, 32'd0);
    rd("post_rst_value", 4'h4, 32'd0);
    rd("post_rst_status", 4'hC, 32'h40);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
